ddr_rx_link_ctrl: RTL
=====================

// Module: ddr_rx_link_ctrl
// PURPOSE
//  Link supervisor for the AT86RF215 DDR I/Q receiver. Sequences the receiver's rst_ddr and waits
//  for its sync flag, then qualifies lock by counting data_valid word strobes.
//  Detects loss of lock, retries with exponential backoff, and raises a sticky fault after
//  MAX_RETRIES consecutive failures. Sits between the host control registers and the DDR receiver.
// PARAMETERS
//  RST_CYCLES    4     width of each rst_ddr pulse, clk cycles (>=1)
//  ACQ_TIMEOUT   1024  max cycles in ACQUIRE waiting for sync=1
//  DV_TIMEOUT    64    max cycles between data_valid rising edges (VERIFY, LOCKED)
//  LOCK_WORDS    8     consecutive good data_valid edges required to declare lock (>=1)
//  MAX_RETRIES   7     failed attempts before FAULT (<=15)
//  BACKOFF_BASE  256   BACKOFF length for retry 1; doubles per retry
// PORTS
//  clk         in   1   receiver clock (same clk as the DDR receiver)
//  rst         in   1   asynchronous, active-high reset
//  enable      in   1   level; 1 = run link, 0 = return to IDLE
//  clr_stats   in   1   1-cycle pulse; clears loss_cnt and the sticky fault
//  sync        in   1   sync flag from DDR receiver
//  data_valid  in   1   word strobe from DDR receiver (rising edge = new I/Q word)
//  rst_ddr     out  1   reset to DDR receiver
//  locked      out  1   1 only in LOCKED
//  fault       out  1   sticky; retries exhausted
//  state       out  3   current state encoding (below)
//  retry_cnt   out  4   failed attempts since last lock/IDLE
//  loss_cnt    out  16  LOCKED->loss events, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async): state=IDLE, rst_ddr=1, locked=0, fault=0, retry_cnt=0, loss_cnt=0.
//  All outputs registered; data_valid edge detect uses one registered delay (dv_q), edge = dv & ~dv_q.
//  States: IDLE=0 RESET=1 ACQUIRE=2 VERIFY=3 LOCKED=4 BACKOFF=5 FAULT=6.
//  IDLE: rst_ddr=1. enable=1 -> RESET; retry_cnt cleared.
//  RESET: rst_ddr=1 exactly RST_CYCLES cycles, then ACQUIRE.
//  ACQUIRE: rst_ddr=0, timer counts up. sync=1 -> VERIFY (good=0, timer=0).
//    timer reaches ACQ_TIMEOUT-1 with sync=0 -> fail.
//  VERIFY: each dv edge: good++, timer=0. good reaches LOCK_WORDS -> LOCKED, retry_cnt=0.
//    sync=0 or timer reaches DV_TIMEOUT-1 without edge -> fail.
//  LOCKED: locked=1; timer cleared on each dv edge. sync=0 or timer reaches DV_TIMEOUT-1 -> loss:
//    loss_cnt++ (saturating), then treated as fail.
//  fail: retry_cnt++ (saturating at 15). If new retry_cnt >= MAX_RETRIES -> FAULT, else BACKOFF.
//  BACKOFF: rst_ddr=1; waits BACKOFF_BASE << (retry_cnt-1) cycles (shift capped at 8), then RESET.
//  FAULT: rst_ddr=1, fault=1. Leaves only via enable=0 (-> IDLE) or clr_stats (-> IDLE).
//    In IDLE, enable=1 restarts normally.
//  enable=0 in any state: next cycle -> IDLE, locked=0, rst_ddr=1; loss_cnt and fault kept.
//  clr_stats in same cycle as a loss event: clear wins (loss_cnt=0).
//  Simultaneous dv edge and timer expiry in same cycle: edge wins (no fail).
//  Simultaneous sync=0 and dv edge: fail wins.
//  Timers sized for max(ACQ_TIMEOUT, DV_TIMEOUT, BACKOFF_BASE<<8) and never wrap.
//  Latency: sync/data_valid to state change = 1 cycle after edge detect (2 clk from input change).
// TESTING
//  enable=1, sync rises 20 cycles after RESET, dv edge every 16 clk
//    -> locked=1 after 8th edge, state=4, retry_cnt=0.
//  Locked link, drop sync for 1 cycle
//    -> locked=0 within 2 clk, loss_cnt=1, BACKOFF 256 cycles with rst_ddr=1, then RESET.
//  sync never asserted -> 7 ACQUIRE timeouts with backoffs 256,512,...; fault=1, state=6, rst_ddr=1.
//  Locked link, dv edges stop (sync stays 1) -> loss after 64 cycles, loss_cnt increments.
//  enable=0 mid-VERIFY -> IDLE next cycle, rst_ddr=1, locked=0.
//  clr_stats in FAULT -> fault=0, loss_cnt=0, state=IDLE.
//  Async rst asserted mid-LOCKED -> all outputs at reset values immediately, without a clk edge.

Source files
------------

// File: rtl/ddr_rx_link_ctrl_if.sv
// Host/receiver-side signal bundle for the DDR RX link supervisor.
// The master drives controls and receiver status; the slave is the supervisor.
interface ddr_rx_link_ctrl_if;
  logic        enable;
  logic        clr_stats;
  logic        sync;
  logic        data_valid;
  logic        rst_ddr;
  logic        locked;
  logic        fault;
  logic [2:0]  state;
  logic [3:0]  retry_cnt;
  logic [15:0] loss_cnt;

  modport master (
    output enable, clr_stats, sync, data_valid,
    input  rst_ddr, locked, fault, state, retry_cnt, loss_cnt
  );

  modport slave (
    input  enable, clr_stats, sync, data_valid,
    output rst_ddr, locked, fault, state, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/ddr_rx_link_ctrl.sv
// Link supervisor for the AT86RF215 DDR I/Q receiver: reset sequencing, sync
// acquisition, lock qualification on data_valid edges, loss detection and backoff retries.
module ddr_rx_link_ctrl #(
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned ACQ_TIMEOUT  = 1024,
  parameter int unsigned DV_TIMEOUT   = 64,
  parameter int unsigned LOCK_WORDS   = 8,
  parameter int unsigned MAX_RETRIES  = 7,
  parameter int unsigned BACKOFF_BASE = 256
) (
  input  logic               clk,
  input  logic               rst,
  ddr_rx_link_ctrl_if.slave  link
);

  localparam int unsigned BO_MAX  = BACKOFF_BASE << 8;
  localparam int unsigned TMR_A   = (ACQ_TIMEOUT > DV_TIMEOUT) ? ACQ_TIMEOUT : DV_TIMEOUT;
  localparam int unsigned TMR_B   = (TMR_A > BO_MAX) ? TMR_A : BO_MAX;
  localparam int unsigned TMR_MAX = (TMR_B > RST_CYCLES) ? TMR_B : RST_CYCLES;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam int unsigned GW      = $clog2(LOCK_WORDS + 1);

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] ACQ_LAST  = TW'(ACQ_TIMEOUT - 1);
  localparam logic [TW-1:0] DV_LAST   = TW'(DV_TIMEOUT - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_WORDS - 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_ACQUIRE = 3'd2,
    S_VERIFY  = 3'd3,
    S_LOCKED  = 3'd4,
    S_BACKOFF = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [GW-1:0] r_good, w_good_nxt;
  logic [3:0]    r_retry, w_retry_nxt;
  logic [15:0]   r_loss, w_loss_nxt;
  logic          r_fault, w_fault_nxt;
  logic          r_locked, w_locked_nxt;
  logic          r_rst_ddr, w_rst_ddr_nxt;
  logic          r_sync, r_dv, r_dv_q;
  logic          w_dv_edge, w_fail;
  logic [3:0]    w_bo_dec, w_bo_shift;
  logic [TW-1:0] w_bo_last;

  assign w_dv_edge  = r_dv & ~r_dv_q;
  assign w_bo_dec   = r_retry - 4'd1;
  assign w_bo_shift = (r_retry == 4'd0) ? 4'd0 : ((w_bo_dec > 4'd8) ? 4'd8 : w_bo_dec);
  assign w_bo_last  = (TW'(BACKOFF_BASE) << w_bo_shift) - TW'(1);

  // Receiver status is registered once before use; dv_q is the edge-detect delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 1'b0;
      r_dv   <= 1'b0;
      r_dv_q <= 1'b0;
    end else begin
      r_sync <= link.sync;
      r_dv   <= link.data_valid;
      r_dv_q <= r_dv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_good    <= '0;
      r_retry   <= '0;
      r_loss    <= '0;
      r_fault   <= 1'b0;
      r_locked  <= 1'b0;
      r_rst_ddr <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_good    <= w_good_nxt;
      r_retry   <= w_retry_nxt;
      r_loss    <= w_loss_nxt;
      r_fault   <= w_fault_nxt;
      r_locked  <= w_locked_nxt;
      r_rst_ddr <= w_rst_ddr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + TW'(1);
    w_good_nxt  = r_good;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    w_fault_nxt = r_fault;
    w_fail      = 1'b0;

    if (!link.enable) begin
      w_state_nxt = S_IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_timer_nxt = '0;
          w_state_nxt = S_RESET;
          w_retry_nxt = '0;
        end
        S_RESET: begin
          if (r_timer == RST_LAST) begin
            w_state_nxt = S_ACQUIRE;
            w_timer_nxt = '0;
          end
        end
        S_ACQUIRE: begin
          if (r_sync) begin
            w_state_nxt = S_VERIFY;
            w_timer_nxt = '0;
            w_good_nxt  = '0;
          end else if (r_timer == ACQ_LAST) begin
            w_fail = 1'b1;
          end
        end
        // Sync loss beats a coincident edge; an edge beats a coincident timeout.
        S_VERIFY: begin
          if (!r_sync) begin
            w_fail = 1'b1;
          end else if (w_dv_edge) begin
            w_timer_nxt = '0;
            if (r_good == GOOD_LAST) begin
              w_state_nxt = S_LOCKED;
              w_retry_nxt = '0;
            end else begin
              w_good_nxt = r_good + GW'(1);
            end
          end else if (r_timer == DV_LAST) begin
            w_fail = 1'b1;
          end
        end
        S_LOCKED: begin
          if (!r_sync || (!w_dv_edge && (r_timer == DV_LAST))) begin
            w_fail = 1'b1;
            if (r_loss != 16'hFFFF) w_loss_nxt = r_loss + 16'd1;
          end else if (w_dv_edge) begin
            w_timer_nxt = '0;
          end
        end
        S_BACKOFF: begin
          if (r_timer == w_bo_last) begin
            w_state_nxt = S_RESET;
            w_timer_nxt = '0;
          end
        end
        S_FAULT: begin
          w_timer_nxt = '0;
          if (link.clr_stats) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end
      endcase

      if (w_fail) begin
        w_timer_nxt = '0;
        w_retry_nxt = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
        w_state_nxt = (w_retry_nxt >= RETRY_LIM) ? S_FAULT : S_BACKOFF;
      end
    end

    if (link.clr_stats) begin
      w_loss_nxt  = '0;
      w_fault_nxt = 1'b0;
    end
    if (w_state_nxt == S_FAULT) w_fault_nxt = 1'b1;

    w_locked_nxt  = (w_state_nxt == S_LOCKED);
    w_rst_ddr_nxt = !((w_state_nxt == S_ACQUIRE) || (w_state_nxt == S_VERIFY) ||
                      (w_state_nxt == S_LOCKED));
  end

  assign link.state     = r_state;
  assign link.rst_ddr   = r_rst_ddr;
  assign link.locked    = r_locked;
  assign link.fault     = r_fault;
  assign link.retry_cnt = r_retry;
  assign link.loss_cnt  = r_loss;

endmodule
